// File: rtl/xbar_slave_arbiter_pkg.sv
// Shared cross-bar types and constants: arbiter state encoding, bus widths,
// slave-select bit and the data returned on a timed-out read.
package xbar_pkg;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int SEL_BIT = 31;

  localparam logic [DATA_W-1:0] ERR_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    RDATA = 2'd2
  } arb_state_t;

endpackage

// File: rtl/xbar_slave_arbiter_if.sv
// Request/acknowledge bus between a cross-bar master and a slave port.
// The master modport drives the request side; the slave modport answers it.
interface xbar_if;
  import xbar_pkg::*;

  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              cmd;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (output req, addr, cmd, wdata, input  ack, rdata);
  modport slave  (input  req, addr, cmd, wdata, output ack, rdata);

endinterface

// File: rtl/xbar_slave_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick: a lone eligible master wins,
// on contention the master that did not win last time is chosen.
module xbar_rr_arb2 (
  input  logic [1:0] elig_i,
  input  logic       last_grant_i,
  output logic       grant_o,
  output logic       valid_o
);

  always_comb begin
    valid_o = |elig_i;
    grant_o = 1'b0;
    if (&elig_i) begin
      grant_o = ~last_grant_i;
    end else begin
      grant_o = elig_i[1];
    end
  end

endmodule

// File: rtl/xbar_slave_arbiter.sv
// Per-slave arbiter of the 2x2 cross-bar: round-robin, one outstanding transaction.
// Define XBAR_ARB_TIMEOUT_EN to complete a stalled BUSY phase with an error after TIMEOUT cycles.
module xbar_slave_arbiter
  import xbar_pkg::*;
#(
  parameter logic SLAVE_ID = 1'b0,
  parameter int   TIMEOUT  = 16
) (
  input  logic    clk,
  input  logic    reset,
  xbar_if.slave   m0,
  xbar_if.slave   m1,
  xbar_if.master  s,
  output logic    timeout_err
);

  arb_state_t state_q, state_d;
  logic       grant_q, grant_d;
  logic       last_grant_q, last_grant_d;

  logic [1:0]        elig;
  logic              arb_grant;
  logic              arb_valid;
  logic              ack_g;
  logic              to_hit;
  logic              rd_err;
  logic [DATA_W-1:0] rd_data;

  assign elig[0] = m0.req & (m0.addr[SEL_BIT] == SLAVE_ID);
  assign elig[1] = m1.req & (m1.addr[SEL_BIT] == SLAVE_ID);

  xbar_rr_arb2 u_rr (
    .elig_i       (elig),
    .last_grant_i (last_grant_q),
    .grant_o      (arb_grant),
    .valid_o      (arb_valid)
  );

`ifdef XBAR_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q;

  assign to_hit = (state_q == BUSY) && (cnt_q == CNT_W'(TIMEOUT));
  assign rd_err = (state_q == RDATA) && err_q;

  // Counter holds at TIMEOUT so the error completion fires exactly once.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q != BUSY) begin
      cnt_d = '0;
    end else if (!s.ack && !to_hit) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= to_hit;
    end
  end
`else
  logic unused_cfg;

  assign to_hit     = 1'b0;
  assign rd_err     = 1'b0;
  assign unused_cfg = (TIMEOUT == 0);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    s.req        = 1'b0;
    ack_g        = 1'b0;
    timeout_err  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          grant_d = arb_grant;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (to_hit) begin
          ack_g        = 1'b1;
          timeout_err  = 1'b1;
          last_grant_d = grant_q;
          state_d      = s.cmd ? IDLE : RDATA;
        end else begin
          s.req = 1'b1;
          ack_g = s.ack;
          if (s.ack) begin
            last_grant_d = grant_q;
            state_d      = s.cmd ? IDLE : RDATA;
          end
        end
      end
      RDATA: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Slave side always follows the granted master; only BUSY qualifies it with s.req.
  always_comb begin
    s.addr  = grant_q ? m1.addr  : m0.addr;
    s.cmd   = grant_q ? m1.cmd   : m0.cmd;
    s.wdata = grant_q ? m1.wdata : m0.wdata;
    m0.ack  = ack_g & ~grant_q;
    m1.ack  = ack_g &  grant_q;
    rd_data = rd_err ? ERR_DATA : s.rdata;
    m0.rdata = grant_q ? '0 : rd_data;
    m1.rdata = grant_q ? rd_data : '0;
  end

endmodule

// File: tb/tb_xbar_slave_arbiter.sv
// Scoreboard bench for xbar_slave_arbiter (SLAVE_ID=0, TIMEOUT=16).
module tb_xbar_slave_arbiter;
  import xbar_pkg::*;

  typedef struct {
    int          m;
    logic        cmd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } txn_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic timeout_err;

  xbar_if m0_if ();
  xbar_if m1_if ();
  xbar_if s_if ();

  txn_t sb[$];
  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  xbar_slave_arbiter #(.SLAVE_ID(1'b0), .TIMEOUT(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .m0          (m0_if.slave),
    .m1          (m1_if.slave),
    .s           (s_if.master),
    .timeout_err (timeout_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int m, input logic cmd, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] rdata);
    txn_t t;
    t.m = m; t.cmd = cmd; t.addr = addr; t.wdata = wdata; t.rdata = rdata;
    sb.push_back(t);
    if (m == 0) begin
      m0_if.req = 1'b1; m0_if.cmd = cmd; m0_if.addr = addr; m0_if.wdata = wdata;
    end else begin
      m1_if.req = 1'b1; m1_if.cmd = cmd; m1_if.addr = addr; m1_if.wdata = wdata;
    end
  endtask

  // Slave responder: waits for s_req, pops the expected transaction and completes it.
  task automatic serve(input int ack_delay);
    txn_t e;
    int n;
    logic [63:0] exp_rd;
    n = 0;
    while (s_if.req !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    n_checks++;
    if (s_if.req !== 1'b1 || sb.size() == 0) begin
      $display("FAIL serve_wait s_req=%b queued=%0d required s_req=1 with a queued txn",
               s_if.req, sb.size());
      return;
    end
    n_pass++;
    e = sb.pop_front();
    n_checks++;
    if ({s_if.addr, s_if.cmd} !== {e.addr, e.cmd})
      $display("FAIL serve_req addr/cmd=%h/%b required %h/%b", s_if.addr, s_if.cmd, e.addr, e.cmd);
    else n_pass++;
    if (e.cmd) begin
      n_checks++;
      if (s_if.wdata !== e.wdata)
        $display("FAIL serve_wdata s_wdata=%h required %h", s_if.wdata, e.wdata);
      else n_pass++;
    end
    repeat (ack_delay) tick();
    s_if.ack = 1'b1;
    #1;
    n_checks++;
    if ({m1_if.ack, m0_if.ack} !== ((e.m == 1) ? 2'b10 : 2'b01))
      $display("FAIL serve_ack m1/m0_ack=%b%b required master %0d only", m1_if.ack, m0_if.ack, e.m);
    else n_pass++;
    tick();
    s_if.ack = 1'b0;
    s_if.rdata = e.rdata;
    if (e.m == 0) m0_if.req = 1'b0; else m1_if.req = 1'b0;
    #1;
    if (!e.cmd) begin
      exp_rd = (e.m == 1) ? {e.rdata, 32'h0} : {32'h0, e.rdata};
      n_checks++;
      if ({s_if.req, dut.state_q} !== {1'b0, RDATA})
        $display("FAIL serve_rdata_state s_req=%b state=%0d required 0/RDATA", s_if.req, dut.state_q);
      else n_pass++;
      n_checks++;
      if ({m1_if.rdata, m0_if.rdata} !== exp_rd)
        $display("FAIL serve_rdata m1/m0_rdata=%h/%h required %h", m1_if.rdata, m0_if.rdata, exp_rd);
      else n_pass++;
      tick();
    end
    n_checks++;
    if ({s_if.req, dut.state_q} !== {1'b0, IDLE})
      $display("FAIL serve_idle s_req=%b state=%0d required 0/IDLE", s_if.req, dut.state_q);
    else n_pass++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    m0_if.req = 1'b0; m1_if.req = 1'b0; s_if.ack = 1'b0; s_if.rdata = 32'h0;
    sb.delete();
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    m0_if.addr = '0; m0_if.cmd = 1'b0; m0_if.wdata = '0;
    m1_if.addr = '0; m1_if.cmd = 1'b0; m1_if.wdata = '0;
    do_reset();
    n_checks++;
    if (dut.state_q !== IDLE) $display("FAIL reset_state state=%0d required IDLE", dut.state_q);
    else n_pass++;
    n_checks++;
    if ({s_if.req, m0_if.ack, m1_if.ack, timeout_err} !== 4'b0000)
      $display("FAIL reset_outputs s_req/m0_ack/m1_ack/err=%b%b%b%b required 0000",
               s_if.req, m0_if.ack, m1_if.ack, timeout_err);
    else n_pass++;
    n_checks++;
    if ({dut.grant_q, dut.last_grant_q} !== 2'b01)
      $display("FAIL reset_grant grant/last=%b%b required 01", dut.grant_q, dut.last_grant_q);
    else n_pass++;
    n_checks++;
    if ({m0_if.rdata, m1_if.rdata} !== 64'h0)
      $display("FAIL reset_rdata m0/m1_rdata=%h/%h required 0", m0_if.rdata, m1_if.rdata);
    else n_pass++;
  endtask

  task automatic test_write();
    do_reset();
    push(0, 1'b1, 32'h0000_0005, 32'hA5A5_A5A5, 32'h0);
    tick();
    n_checks++;
    if (s_if.req !== 1'b1) $display("FAIL write_latency s_req=%b required 1", s_if.req);
    else n_pass++;
    serve(1);
    n_checks++;
    if (timeout_err !== 1'b0) $display("FAIL write_err timeout_err=%b required 0", timeout_err);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    do_reset();
    push(0, 1'b0, 32'h0000_0010, 32'h0, 32'h0101_0101);
    push(1, 1'b0, 32'h0000_0020, 32'h0, 32'h0202_0202);
    serve(0);
    serve(0);
    push(0, 1'b0, 32'h0000_0030, 32'h0, 32'h0303_0303);
    push(1, 1'b1, 32'h0000_0040, 32'hCAFE_F00D, 32'h0);
    serve(0);
    serve(2);
  endtask

  task automatic test_read_m1();
    do_reset();
    push(1, 1'b0, 32'h0000_0003, 32'h0, 32'h1234_5678);
    serve(1);
  endtask

  task automatic test_other_slave();
    logic seen;
    do_reset();
    seen = 1'b0;
    m0_if.req = 1'b1; m0_if.cmd = 1'b0; m0_if.addr = 32'h8000_0001;
    repeat (20) begin
      tick();
      if (s_if.req !== 1'b0 || m0_if.ack !== 1'b0) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) $display("FAIL other_slave activity=%b required 0", seen);
    else n_pass++;
    m0_if.req = 1'b0;
  endtask

  task automatic test_reset_busy();
    do_reset();
    push(0, 1'b1, 32'h0000_0008, 32'h5A5A_0001, 32'h0);
    tick();
    reset = 1'b1;
    tick();
    n_checks++;
    if ({s_if.req, m0_if.ack, m1_if.ack, dut.state_q} !== {3'b000, IDLE})
      $display("FAIL reset_busy s_req/acks=%b%b%b state=%0d required 000/IDLE",
               s_if.req, m0_if.ack, m1_if.ack, dut.state_q);
    else n_pass++;
    reset = 1'b0;
    serve(1);
  endtask

`ifdef XBAR_ARB_TIMEOUT_EN
  task automatic test_timeout();
    logic bad;
    do_reset();
    bad = 1'b0;
    s_if.rdata = 32'h5555_5555;
    m0_if.req = 1'b1; m0_if.cmd = 1'b0; m0_if.addr = 32'h0000_0044;
    tick();
    repeat (16) begin
      if (s_if.req !== 1'b1 || m0_if.ack !== 1'b0 || timeout_err !== 1'b0) bad = 1'b1;
      tick();
    end
    n_checks++;
    if (bad !== 1'b0) $display("FAIL timeout_wait early completion=%b required 0", bad);
    else n_pass++;
    n_checks++;
    if ({m0_if.ack, timeout_err, s_if.req} !== 3'b110)
      $display("FAIL timeout_fire m0_ack/err/s_req=%b%b%b required 110",
               m0_if.ack, timeout_err, s_if.req);
    else n_pass++;
    m0_if.req = 1'b0;
    tick();
    n_checks++;
    if ({m0_if.rdata, timeout_err} !== {32'hDEAD_BEEF, 1'b0})
      $display("FAIL timeout_rdata m0_rdata=%h err=%b required DEADBEEF/0", m0_if.rdata, timeout_err);
    else n_pass++;
    tick();
    n_checks++;
    if (dut.state_q !== IDLE) $display("FAIL timeout_idle state=%0d required IDLE", dut.state_q);
    else n_pass++;
  endtask
`else
  task automatic test_timeout();
    logic bad;
    do_reset();
    bad = 1'b0;
    push(0, 1'b0, 32'h0000_0044, 32'h0, 32'h7777_8888);
    tick();
    repeat (40) begin
      if (s_if.req !== 1'b1 || m0_if.ack !== 1'b0 || timeout_err !== 1'b0) bad = 1'b1;
      tick();
    end
    n_checks++;
    if (bad !== 1'b0) $display("FAIL no_timeout early completion=%b required 0", bad);
    else n_pass++;
    serve(0);
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_round_robin();
    test_read_m1();
    test_other_slave();
    test_reset_busy();
    test_timeout();
    n_checks++;
    if (sb.size() != 0) $display("FAIL scoreboard_drain left=%0d required 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
